// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : VGA raster timing generator. A sys_clk divider produces one
//             pixel slot every CLK_DIV cycles. Horizontal and vertical
//             counters walk the raster. Sync, data-enable, pixel coordinates,
//             line/frame strobes and an optional colour-bar test pattern are
//             all registered on the edge where the counters advance.
//  Options  : define VGA_TIMING_PATTERN_EN to build the 8-bar test pattern.
//             Without it, pat_r/pat_g/pat_b are constant zero.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CLK_DIV   = 4
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       en,
   output logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       DE,
   output logic [9:0] x_pixel,
   output logic [9:0] y_pixel,
   output logic       frame_start,
   output logic       line_start,
   output logic [3:0] pat_r,
   output logic [3:0] pat_g,
   output logic [3:0] pat_b
);

   // -------------------------------------------------------------------------
   // Derived geometry
   // -------------------------------------------------------------------------
   localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   // A single-cycle divider still needs a 1-bit register to stay legal.
   localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

   localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
   localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
   localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] c_HS_BEGIN = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] c_VS_BEGIN = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [c_DIV_W-1:0] r_div_cnt;
   logic [9:0]         r_h_cnt;
   logic [9:0]         r_v_cnt;

   logic               r_pix_tick;
   logic               r_line_start;
   logic               r_frame_start;
   logic               r_de;
   logic               r_hsync;
   logic               r_vsync;
   logic [9:0]         r_x_pixel;
   logic [9:0]         r_y_pixel;

   // -------------------------------------------------------------------------
   // Next-position decode. Every registered output is computed from the
   // counters' next value so that outputs and counters move on the same edge.
   // -------------------------------------------------------------------------
   logic       w_tick;
   logic       w_h_wrap;
   logic       w_v_wrap;
   logic [9:0] w_h_next;
   logic [9:0] w_v_next;
   logic       w_de_next;
   logic       w_hsync_next;
   logic       w_vsync_next;

   assign w_tick   = en && (r_div_cnt == c_DIV_LAST);
   assign w_h_wrap = (r_h_cnt == c_H_LAST);
   assign w_v_wrap = (r_v_cnt == c_V_LAST);

   assign w_h_next = w_h_wrap ? 10'd0 : (r_h_cnt + 10'd1);
   assign w_v_next = !w_h_wrap ? r_v_cnt
                   : (w_v_wrap ? 10'd0 : (r_v_cnt + 10'd1));

   assign w_de_next    = (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
   // Syncs are active-low: low only inside the sync pulse window.
   assign w_hsync_next = !((w_h_next >= c_HS_BEGIN) && (w_h_next < c_HS_END));
   assign w_vsync_next = !((w_v_next >= c_VS_BEGIN) && (w_v_next < c_VS_END));

   // Pixel-slot divider: counts only while enabled, so a pause keeps its phase.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_div_cnt <= '0;
      end else if (en) begin
         if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end
      end
   end

   // Raster counters: reset to the last slot so the first tick lands on (0,0).
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_h_cnt <= c_H_LAST;
         r_v_cnt <= c_V_LAST;
      end else if (w_tick) begin
         r_h_cnt <= w_h_next;
         r_v_cnt <= w_v_next;
      end
   end

   // Single-cycle strobes: follow the tick, so a disabled cycle clears them.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_pix_tick    <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pix_tick    <= w_tick;
         r_line_start  <= w_tick && (w_h_next == 10'd0);
         r_frame_start <= w_tick && (w_h_next == 10'd0) && (w_v_next == 10'd0);
      end
   end

   // Level outputs: updated only on a pixel slot, held otherwise.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_de      <= 1'b0;
         r_hsync   <= 1'b1;
         r_vsync   <= 1'b1;
         r_x_pixel <= 10'd0;
         r_y_pixel <= 10'd0;
      end else if (w_tick) begin
         r_de      <= w_de_next;
         r_hsync   <= w_hsync_next;
         r_vsync   <= w_vsync_next;
         r_x_pixel <= w_de_next ? w_h_next : 10'd0;
         r_y_pixel <= w_de_next ? w_v_next : 10'd0;
      end
   end

   assign pix_tick    = r_pix_tick;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign DE          = r_de;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign x_pixel     = r_x_pixel;
   assign y_pixel     = r_y_pixel;

`ifdef VGA_TIMING_PATTERN_EN
   // -------------------------------------------------------------------------
   // Colour bars: eight equal-width vertical bars across the visible line,
   // ordered white, yellow, cyan, green, magenta, red, blue, black.
   // -------------------------------------------------------------------------
   localparam int c_BAR_W = H_VISIBLE / 8;

   logic [2:0]  w_bar;
   logic [11:0] w_pat_next;
   logic [3:0]  r_pat_r;
   logic [3:0]  r_pat_g;
   logic [3:0]  r_pat_b;

   // Bar index from a threshold chain, avoiding a divider on the pixel path.
   always_comb begin
      w_bar = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (w_h_next >= 10'(i * c_BAR_W)) begin
            w_bar = 3'(i);
         end
      end
   end

   // Bar index to full-scale RGB.
   always_comb begin
      w_pat_next = 12'h000;
      case (w_bar)
         3'd0:    w_pat_next = 12'hFFF;
         3'd1:    w_pat_next = 12'hFF0;
         3'd2:    w_pat_next = 12'h0FF;
         3'd3:    w_pat_next = 12'h0F0;
         3'd4:    w_pat_next = 12'hF0F;
         3'd5:    w_pat_next = 12'hF00;
         3'd6:    w_pat_next = 12'h00F;
         default: w_pat_next = 12'h000;
      endcase
   end

   // Pattern registers move with DE and are black outside the visible window.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_pat_r <= 4'h0;
         r_pat_g <= 4'h0;
         r_pat_b <= 4'h0;
      end else if (w_tick) begin
         if (w_de_next) begin
            r_pat_r <= w_pat_next[11:8];
            r_pat_g <= w_pat_next[7:4];
            r_pat_b <= w_pat_next[3:0];
         end else begin
            r_pat_r <= 4'h0;
            r_pat_g <= 4'h0;
            r_pat_b <= 4'h0;
         end
      end
   end

   assign pat_r = r_pat_r;
   assign pat_g = r_pat_g;
   assign pat_b = r_pat_b;
`else
   // Pattern generator not built: colour outputs are constant black.
   assign pat_r = 4'h0;
   assign pat_g = 4'h0;
   assign pat_b = 4'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. One instance runs the
//             default 640x480 geometry; a second, tiny geometry runs whole
//             frames quickly. Both share clock, reset and enable and are
//             compared every cycle against a raster model that derives the
//             position from the number of enabled cycles since reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PATTERN_EN
   localparam bit PAT_ON = 1'b1;
`else
   localparam bit PAT_ON = 1'b0;
`endif

   // Small geometry: 24 slots per line, 10 lines, 3 sys_clk per slot.
   localparam int S_HV = 16, S_HFP = 2, S_HS = 3, S_HBP = 3;
   localparam int S_VV = 6,  S_VFP = 1, S_VS = 2, S_VBP = 1;
   localparam int S_DIV = 3;

   logic clk = 1'b0;
   logic r_reset_n;
   logic r_en;

   logic       w_d_tick, w_d_hs, w_d_vs, w_d_de, w_d_fs, w_d_ls;
   logic [9:0] w_d_x, w_d_y;
   logic [3:0] w_d_r, w_d_g, w_d_b;
   logic       w_s_tick, w_s_hs, w_s_vs, w_s_de, w_s_fs, w_s_ls;
   logic [9:0] w_s_x, w_s_y;
   logic [3:0] w_s_r, w_s_g, w_s_b;

   always #5 clk = ~clk;

   vga_timing_gen u_dut (
      .sys_clk(clk), .reset(r_reset_n), .en(r_en),
      .pix_tick(w_d_tick), .hsync(w_d_hs), .vsync(w_d_vs), .DE(w_d_de),
      .x_pixel(w_d_x), .y_pixel(w_d_y), .frame_start(w_d_fs), .line_start(w_d_ls),
      .pat_r(w_d_r), .pat_g(w_d_g), .pat_b(w_d_b)
   );

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
      .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
      .CLK_DIV(S_DIV)
   ) u_small (
      .sys_clk(clk), .reset(r_reset_n), .en(r_en),
      .pix_tick(w_s_tick), .hsync(w_s_hs), .vsync(w_s_vs), .DE(w_s_de),
      .x_pixel(w_s_x), .y_pixel(w_s_y), .frame_start(w_s_fs), .line_start(w_s_ls),
      .pat_r(w_s_r), .pat_g(w_s_g), .pat_b(w_s_b)
   );

   logic [37:0] w_d_obs, w_s_obs;
   assign w_d_obs = {w_d_tick, w_d_ls, w_d_fs, w_d_de, w_d_hs, w_d_vs, w_d_x, w_d_y, w_d_r, w_d_g, w_d_b};
   assign w_s_obs = {w_s_tick, w_s_ls, w_s_fs, w_s_de, w_s_hs, w_s_vs, w_s_x, w_s_y, w_s_r, w_s_g, w_s_b};

   int     n_checks = 0;
   int     n_errors = 0;
   longint m_e;        // enabled edges since reset release
   bit     m_last_en;  // was the most recent edge an enabled one

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raster model: slot count -> linear raster index -> (h, v) -> outputs.
   function automatic logic [37:0] model_out(input int hv, hfp, hs, hbp, vv, vfp, vs, vbp, div,
                                             input longint e, input bit last_en);
      int ht, vt, h, v;
      longint total, lin;
      bit tick, de, hs_n, vs_n;
      logic [11:0] pat;
      logic [11:0] bars [8];
      bars  = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      ht    = hv + hfp + hs + hbp;
      vt    = vv + vfp + vs + vbp;
      total = longint'(ht) * vt;
      lin   = (e / div + total - 1) % total;
      h     = int'(lin % ht);
      v     = int'(lin / ht);
      tick  = last_en && (e % div == 0);
      de    = (h < hv) && (v < vv);
      hs_n  = !((h >= hv + hfp) && (h < hv + hfp + hs));
      vs_n  = !((v >= vv + vfp) && (v < vv + vfp + vs));
      pat   = (PAT_ON && de) ? bars[h / (hv / 8)] : 12'h000;
      return {tick, tick && (h == 0), tick && (lin == 0), de, hs_n, vs_n,
              de ? 10'(h) : 10'd0, de ? 10'(v) : 10'd0, pat};
   endfunction

   task automatic step(input logic e_in);
      r_en = e_in;
      @(posedge clk);
      #1;
      if (r_reset_n) begin
         if (e_in) m_e++;
         m_last_en = e_in;
      end else begin
         m_e       = 0;
         m_last_en = 1'b0;
      end
      chk("dflt_vec", w_d_obs, model_out(640, 16, 96, 48, 480, 10, 2, 33, 4, m_e, m_last_en));
      chk("small_vec", w_s_obs, model_out(S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP,
                                          S_DIV, m_e, m_last_en));
   endtask

   // Release reset with en high and check the first slot lands on the 4th edge.
   task automatic release_and_check_first(input string tag);
      r_reset_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step(1'b1);
         if (k < 4) chk({tag, "_no_early_tick"}, w_d_tick, 1'b0);
      end
      chk({tag, "_tick"}, w_d_tick, 1'b1);
      chk({tag, "_frame_start"}, w_d_fs, 1'b1);
      chk({tag, "_line_start"}, w_d_ls, 1'b1);
      chk({tag, "_de"}, w_d_de, 1'b1);
      chk({tag, "_xy"}, {w_d_x, w_d_y}, 20'd0);
      chk({tag, "_pat_x0"}, {w_d_r, w_d_g, w_d_b}, PAT_ON ? 12'hFFF : 12'h000);
   endtask

   int ls_seen, tcnt, hs_start, hs_len, line_len;
   bit prev_hs, found;
   int s_state, s_cyc, s_ticks, s_de, s_lines, s_vs_lines, s_vs_first;
   bit f85, f639, fblank;

   initial begin
      r_reset_n = 1'b0;
      r_en      = 1'b0;
      m_e       = 0;
      m_last_en = 1'b0;

      // Held in reset: idle values.
      repeat (3) step(1'b0);
      chk("rst_sync", {w_d_hs, w_d_vs, w_d_de}, 3'b110);
      chk("rst_strobes", {w_d_tick, w_d_ls, w_d_fs}, 3'b000);

      release_and_check_first("start");

      // Line 0 of the default raster: sync placement and line length.
      ls_seen = 1; tcnt = 0; hs_start = -1; hs_len = 0; line_len = 0; prev_hs = 1'b1;
      s_state = 0; s_cyc = 0; s_ticks = 0; s_de = 0; s_lines = 0; s_vs_lines = 0; s_vs_first = -1;
      for (int c = 0; c < 4000 && ls_seen < 2; c++) begin
         step(1'b1);
         if (w_d_tick) begin
            if (w_d_ls) begin
               if (ls_seen == 1) line_len = tcnt + 1;
               ls_seen++;
               tcnt = 0;
            end else begin
               tcnt++;
            end
            if (ls_seen == 1 && !w_d_hs) begin
               hs_len++;
               if (prev_hs) hs_start = tcnt;
            end
            prev_hs = w_d_hs;
         end
         // Small raster: measure one complete frame between frame_starts.
         if (s_state == 1) s_cyc++;
         if (w_s_tick) begin
            if (w_s_fs) begin
               if (s_state == 1) s_state = 2;
               else if (s_state == 0) s_state = 1;
            end
            if (s_state == 1) begin
               s_ticks++;
               if (w_s_de) s_de++;
               if (w_s_ls) begin
                  s_lines++;
                  if (!w_s_vs) begin
                     s_vs_lines++;
                     if (s_vs_first < 0) s_vs_first = s_lines - 1;
                  end
               end
            end
         end
      end
      chk("line1_reached", ls_seen, 2);
      chk("line_len", line_len, 800);
      chk("hsync_start", hs_start, 656);
      chk("hsync_len", hs_len, 96);
      chk("small_frame_done", s_state, 2);
      chk("small_frame_cycles", s_cyc, 720);
      chk("small_frame_ticks", s_ticks, 240);
      chk("small_de_ticks", s_de, 96);
      chk("small_lines", s_lines, 10);
      chk("small_vsync_lines", s_vs_lines, 2);
      chk("small_vsync_first", s_vs_first, 7);

      // Freeze mid-line at (100, 1) with the divider part-way through a slot.
      found = 1'b0;
      for (int c = 0; c < 1000 && !found; c++) begin
         step(1'b1);
         if (w_d_tick && w_d_de && w_d_x == 10'd100 && w_d_y == 10'd1) found = 1'b1;
      end
      chk("freeze_point_reached", found, 1'b1);
      step(1'b1);
      for (int c = 0; c < 37; c++) begin
         step(1'b0);
         chk("freeze_hold", w_d_obs,
             {3'b000, 3'b111, 10'd100, 10'd1, PAT_ON ? 12'hFF0 : 12'h000});
      end
      step(1'b1);
      chk("resume_wait1", {w_d_tick, w_d_x}, {1'b0, 10'd100});
      step(1'b1);
      chk("resume_wait2", {w_d_tick, w_d_x}, {1'b0, 10'd100});
      step(1'b1);
      chk("resume_x101", {w_d_tick, w_d_x}, {1'b1, 10'd101});

      // Random enable gating.
      for (int c = 0; c < 2000; c++) step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

      // Asynchronous reset between edges: outputs drop at once.
      #3;
      r_reset_n = 1'b0;
      #1;
      m_e = 0;
      m_last_en = 1'b0;
      chk("async_rst_dflt", w_d_obs, model_out(640, 16, 96, 48, 480, 10, 2, 33, 4, m_e, m_last_en));
      chk("async_rst_small", w_s_obs, model_out(S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP,
                                                S_DIV, m_e, m_last_en));
      chk("async_rst_levels", {w_d_de, w_d_hs, w_d_vs, w_d_x, w_d_y}, {3'b011, 20'd0});
      repeat (2) step(1'b1);
      release_and_check_first("restart");

      // Pattern across line 0 and into its blanking.
      f85 = 1'b0; f639 = 1'b0; fblank = 1'b0;
      for (int c = 0; c < 3000 && !fblank; c++) begin
         step(1'b1);
         if (w_d_tick && w_d_de && w_d_x == 10'd85) begin
            f85 = 1'b1;
            chk("pat_x85", {w_d_r, w_d_g, w_d_b}, PAT_ON ? 12'hFF0 : 12'h000);
         end
         if (w_d_tick && w_d_de && w_d_x == 10'd639) begin
            f639 = 1'b1;
            chk("pat_x639", {w_d_r, w_d_g, w_d_b}, 12'h000);
         end
         if (w_d_tick && !w_d_de) begin
            fblank = 1'b1;
            chk("pat_blank", {w_d_r, w_d_g, w_d_b}, 12'h000);
         end
      end
      chk("pat_points_seen", {f85, f639, fblank}, 3'b111);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
